pixel_writeback: RTL

- Receiving end of the raytracing controller's pixel output stream: pixel_valid_in, pixel_x_in, pixel_y_in, pixel_value_in.
- The pixel stream has no backpressure, so this block computes a linear framebuffer address for each pixel, buffers it in a small FIFO, and writes it to the framebuffer memory port through a valid/ready handshake.
- Tracks per-frame completion and flags dropped pixels.

---
 rtl/pixel_writeback_if.sv | 15 +
 rtl/pixel_writeback.sv | 133 +++++++++++++
 2 files changed

// File: rtl/pixel_writeback_if.sv
// Framebuffer write port of pixel_writeback; FB_AW carries the bank bit when
// double buffering is enabled.
interface pixel_writeback_if #(
  parameter int FB_AW = 16
);
  // A write transfers on every cycle where fb_wr_en and fb_ready are both high;
  // while fb_wr_en is high and fb_ready low, fb_addr and fb_data hold stable.
  logic             fb_wr_en;
  logic [FB_AW-1:0] fb_addr;
  logic [15:0]      fb_data;
  logic             fb_ready;

  modport master (output fb_wr_en, output fb_addr, output fb_data, input fb_ready);
  modport slave  (input fb_wr_en, input fb_addr, input fb_data, output fb_ready);
endinterface

// File: rtl/pixel_writeback.sv
// Pixel stream to framebuffer writer: linear address, small show-ahead FIFO, frame tracking.
// Optional macro PIXEL_WRITEBACK_DOUBLE_BUFFER_EN adds a bank bit on fb_addr and display_bank.
module pixel_writeback #(
  parameter int SCREEN_WIDTH  = 320,
  parameter int SCREEN_HEIGHT = 180,
  parameter int FIFO_DEPTH    = 8,
  parameter int ADDR_WIDTH    = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             frame_start,
  input  logic                             pixel_valid_in,
  input  logic [$clog2(SCREEN_WIDTH)-1:0]  pixel_x_in,
  input  logic [$clog2(SCREEN_HEIGHT)-1:0] pixel_y_in,
  input  logic [15:0]                      pixel_value_in,
  pixel_writeback_if.master                fb,
  output logic                             busy,
  output logic                             frame_done,
  output logic [ADDR_WIDTH-1:0]            pixels_written,
  output logic                             overflow,
  output logic                             range_err,
`ifdef PIXEL_WRITEBACK_DOUBLE_BUFFER_EN
  output logic                             display_bank,
`endif
  output logic                             state_dbg
);
  localparam int XW    = $clog2(SCREEN_WIDTH);
  localparam int YW    = $clog2(SCREEN_HEIGHT);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int TOTAL = SCREEN_WIDTH * SCREEN_HEIGHT;

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;
  state_t state;

  logic                  in_vld;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [15:0]           in_data;

  logic [ADDR_WIDTH+15:0] mem [FIFO_DEPTH];
  logic [PW:0]            wr_ptr, rd_ptr;
  logic [PW:0]            count;
  logic [PW+1:0]          occ;
  logic                   empty, full, in_range, fire;
  logic [ADDR_WIDTH-1:0]  lin_addr;
  logic [ADDR_WIDTH+15:0] head;

`ifdef PIXEL_WRITEBACK_DOUBLE_BUFFER_EN
  logic write_bank;
  assign display_bank = ~write_bank;
`endif

  assign count    = wr_ptr - rd_ptr;
  assign empty    = (count == '0);
  // The registered input stage is counted as occupancy, so a pushed entry always finds room.
  assign occ      = {1'b0, count} + (PW+2)'(in_vld);
  assign full     = (occ >= (PW+2)'(FIFO_DEPTH));
  assign in_range = (32'(pixel_x_in) < SCREEN_WIDTH) && (32'(pixel_y_in) < SCREEN_HEIGHT);
  assign lin_addr = ADDR_WIDTH'(pixel_y_in) * ADDR_WIDTH'(SCREEN_WIDTH) + ADDR_WIDTH'(pixel_x_in);
  assign head     = mem[rd_ptr[PW-1:0]];
  assign fire     = fb.fb_wr_en && fb.fb_ready;

  assign fb.fb_wr_en = !empty;
  assign fb.fb_data  = head[15:0];
`ifdef PIXEL_WRITEBACK_DOUBLE_BUFFER_EN
  assign fb.fb_addr  = {write_bank, head[ADDR_WIDTH+15:16]};
`else
  assign fb.fb_addr  = head[ADDR_WIDTH+15:16];
`endif

  assign busy      = (state == ACTIVE) || !empty;
  assign state_dbg = (state == ACTIVE);

  always_ff @(posedge clk) begin
    if (in_vld) mem[wr_ptr[PW-1:0]] <= {in_addr, in_data};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      in_vld         <= 1'b0;
      in_addr        <= '0;
      in_data        <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      frame_done     <= 1'b0;
      pixels_written <= '0;
      overflow       <= 1'b0;
      range_err      <= 1'b0;
`ifdef PIXEL_WRITEBACK_DOUBLE_BUFFER_EN
      write_bank     <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      if (frame_start) begin
        // Flush wins over any pending write and over a pixel arriving this cycle.
        state          <= ACTIVE;
        in_vld         <= 1'b0;
        wr_ptr         <= '0;
        rd_ptr         <= '0;
        pixels_written <= '0;
        overflow       <= 1'b0;
        range_err      <= 1'b0;
      end else begin
        in_vld <= 1'b0;
        if (state == ACTIVE && pixel_valid_in) begin
          if (!in_range) begin
            range_err <= 1'b1;
          end else if (full) begin
            overflow <= 1'b1;
          end else begin
            in_vld  <= 1'b1;
            in_addr <= lin_addr;
            in_data <= pixel_value_in;
          end
        end
        if (in_vld) wr_ptr <= wr_ptr + 1'b1;
        if (fire) begin
          rd_ptr <= rd_ptr + 1'b1;
          if (state == ACTIVE) begin
            pixels_written <= pixels_written + 1'b1;
            if (pixels_written == ADDR_WIDTH'(TOTAL - 1)) begin
              frame_done <= 1'b1;
              state      <= IDLE;
`ifdef PIXEL_WRITEBACK_DOUBLE_BUFFER_EN
              write_bank <= ~write_bank;
`endif
            end
          end
        end
      end
    end
  end
endmodule
